// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with single-word holding register.
// One clock domain (clk_25mhz). The line is synchronized, a falling edge arms
// the receiver, and each bit is sampled once at its midpoint by a down-counter.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and an extra parity_error output pulse.
`timescale 1ns/1ps

module uart_rx_core #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk_25mhz,
   input  logic                 reset,
   input  logic                 rx_data,
   input  logic                 rd_ack,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_error,
`endif
   output logic                 overrun,
   output logic                 sample_tick,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   // First sample lands mid start bit; later samples are a full bit apart.
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif

   logic sync1;
   logic rxs;
   logic rxs_d;
   logic fall;

`ifdef UART_RX_PARITY_EN
   // Even parity: data plus parity bit must carry an even number of ones.
   function automatic logic odd_weight(input logic [DATA_BITS-1:0] word,
                                       input logic pbit);
      return ^{word, pbit};
   endfunction
`endif

   // Two-flop synchronizer plus one delayed copy for edge detection; idle high.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rx_data;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // A held-low line never looks like a new edge, so no retrigger after a bad stop.
   assign fall = rxs_d & ~rxs;

   // Receive FSM with registered outputs and the consumer handshake.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         shreg        <= '0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         frame_error  <= 1'b0;
         overrun      <= 1'b0;
         sample_tick  <= 1'b0;
         busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_error <= 1'b0;
`endif
      end else begin
         sample_tick <= 1'b0;
         frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error <= 1'b0;
`endif
         // Ack consumes the held word; a good frame landing on the same edge
         // overrides data_valid below and sees the word as consumed.
         if (rd_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  cnt   <= HALF_LOAD;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (cnt == '0) begin
                  sample_tick <= 1'b1;
                  if (!rxs) begin
                     state <= DATA;
                     cnt   <= BIT_LOAD;
                     idx   <= '0;
                  end else begin
                     // Glitch: line was high again at mid start bit.
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            DATA: begin
               if (cnt == '0) begin
                  sample_tick <= 1'b1;
                  cnt         <= BIT_LOAD;
                  shreg       <= {rxs, shreg[DATA_BITS-1:1]};
                  if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == '0) begin
                  sample_tick <= 1'b1;
                  cnt         <= BIT_LOAD;
                  par_bit     <= rxs;
                  state       <= STOP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif

            STOP: begin
               if (cnt == '0) begin
                  sample_tick <= 1'b1;
                  state       <= IDLE;
                  busy        <= 1'b0;
                  if (!rxs) begin
                     frame_error <= 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  if (odd_weight(shreg, par_bit)) begin
                     parity_error <= 1'b1;
                  end
                  if (rxs && !odd_weight(shreg, par_bit)) begin
`else
                  if (rxs) begin
`endif
                     data_out   <= shreg;
                     data_valid <= 1'b1;
                     // Word lost only if the previous one is still unread.
                     overrun    <= data_valid & ~rd_ack;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core (CLKS_PER_BIT=4, DATA_BITS=8).
`timescale 1ns/1ps

module tb_uart_rx_core;

   localparam int CPB = 4;
   localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = DB + 3;
`else
   localparam int NBITS = DB + 2;
`endif
   // Edge (counted from the first edge that sees the start bit) of the stop sample.
   localparam int STOP_EDGE = 2 + CPB / 2 + (NBITS - 1) * CPB;

   logic          clk_25mhz = 1'b0;
   logic          reset;
   logic          rx_data;
   logic          rd_ack;
   logic [DB-1:0] data_out;
   logic          data_valid;
   logic          frame_error;
   logic          overrun;
   logic          sample_tick;
   logic          busy;
`ifdef UART_RX_PARITY_EN
   logic          parity_error;
`endif

   int tests = 0;
   int fails = 0;

   int tick_total = 0;
   int fe_total   = 0;
   int busy_total = 0;
   int pe_total   = 0;

   // Reference model of the holding register.
   logic [DB-1:0] m_data;
   logic          m_valid;
   logic          m_ovr;

   uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk_25mhz   (clk_25mhz),
      .reset       (reset),
      .rx_data     (rx_data),
      .rd_ack      (rd_ack),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_error (frame_error),
`ifdef UART_RX_PARITY_EN
      .parity_error(parity_error),
`endif
      .overrun     (overrun),
      .sample_tick (sample_tick),
      .busy        (busy)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   always @(negedge clk_25mhz) begin
      if (sample_tick) tick_total <= tick_total + 1;
      if (frame_error) fe_total   <= fe_total + 1;
      if (busy)        busy_total <= busy_total + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pe_total <= pe_total + 1;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_data"},    32'(data_out),   32'(m_data));
      check({tag, "_valid"},   32'(data_valid), 32'(m_valid));
      check({tag, "_overrun"}, 32'(overrun),    32'(m_ovr));
   endtask

   // Ack consumes the held word (ignored when nothing is held).
   task automatic model_ack();
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   // A frame ends: a same-edge ack consumes first, then a good word lands,
   // and it is an overrun only if an unread word is still held.
   task automatic model_frame(input logic [DB-1:0] d, input bit good, input bit ack_same);
      if (ack_same) model_ack();
      if (good) begin
         if (m_valid) m_ovr = 1'b1;
         m_data  = d;
         m_valid = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      rx_data = 1'b1;
      repeat (n) @(posedge clk_25mhz);
      #1;
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      @(posedge clk_25mhz);
      #1;
      rd_ack = 1'b0;
   endtask

   // Drives one whole frame, then runs until just past the stop sample.
   task automatic send_frame(input logic [DB-1:0] d, input bit stop_bit, input bit par_flip,
                             input bit ack_at_stop, input bit tail_low);
      logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
      bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
`else
      bits = {stop_bit, d, 1'b0};
      if (par_flip) bits = {stop_bit, d, 1'b0};
`endif
      for (int c = 0; c <= STOP_EDGE + 1; c++) begin
         rx_data = (c < NBITS * CPB) ? bits[c / CPB] : !tail_low;
         rd_ack  = ack_at_stop && (c == STOP_EDGE);
         @(posedge clk_25mhz);
         #1;
      end
      rd_ack = 1'b0;
   endtask

   initial begin
      int t0, f0, b0, p0;
      logic [NBITS-1:0] rbits;

      reset   = 1'b1;
      rx_data = 1'b1;
      rd_ack  = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      repeat (2) @(posedge clk_25mhz);
      #1;
      check("rst_data",  32'(data_out),    32'h0);
      check("rst_valid", 32'(data_valid),  32'h0);
      check("rst_fe",    32'(frame_error), 32'h0);
      check("rst_ovr",   32'(overrun),     32'h0);
      check("rst_tick",  32'(sample_tick), 32'h0);
      check("rst_busy",  32'(busy),        32'h0);
      reset = 1'b0;
      idle(4);

      // Good frame 0xA5.
      t0 = tick_total; f0 = fe_total;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(8'hA5, 1'b1, 1'b0);
      check_model("a5");
      check("a5_ticks", 32'(tick_total - t0), 32'(NBITS));
      check("a5_fe",    32'(fe_total - f0),   32'h0);
      check("a5_busy",  32'(busy),            32'h0);
      idle(2);

      // Ack clears valid, keeps the word; a second ack is ignored.
      pulse_ack(); model_ack();
      check_model("ack1");
      pulse_ack(); model_ack();
      check_model("ack_idle");

      // Bad stop on 0x3C, then line held low.
      t0 = tick_total; f0 = fe_total;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      model_frame(8'h3C, 1'b0, 1'b0);
      check("3c_fe", 32'(fe_total - f0), 32'h1);
      check_model("3c");
      b0 = busy_total; t0 = tick_total;
      repeat (40) @(posedge clk_25mhz);
      #1;
      check("low_busy",  32'(busy_total - b0), 32'h0);
      check("low_ticks", 32'(tick_total - t0), 32'h0);
      idle(4);

      // One-cycle glitch: false start, back to idle at the midpoint.
      t0 = tick_total; f0 = fe_total; b0 = busy_total;
      rx_data = 1'b0;
      @(posedge clk_25mhz); #1;
      idle(12);
      check("glitch_busy",  32'(busy_total - b0), 32'(CPB / 2));
      check("glitch_ticks", 32'(tick_total - t0), 32'h1);
      check("glitch_fe",    32'(fe_total - f0),   32'h0);
      check_model("glitch");

      // Two frames without ack -> overrun; ack clears both.
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(8'h11, 1'b1, 1'b0);
      idle(2);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(8'h22, 1'b1, 1'b0);
      check_model("ovr");
      check("ovr_set", 32'(overrun), 32'h1);
      pulse_ack(); model_ack();
      check_model("ovr_ack");

      // Overrun pending, then a frame completing on the ack edge.
      send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(8'h33, 1'b1, 1'b0);
      idle(2);
      send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(8'h44, 1'b1, 1'b0);
      idle(2);
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
      model_frame(8'h55, 1'b1, 1'b1);
      check_model("same_edge");
      idle(2);

      // Randomized frames, errors and acks against the model.
      for (int i = 0; i < 12; i++) begin
         logic [DB-1:0] d;
         bit st, pf;
         int mode;
         d    = DB'($urandom);
         st   = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
         pf   = ($urandom_range(0, 3) == 0);
`else
         pf   = 1'b0;
`endif
         mode = $urandom_range(0, 2);
         if (mode == 1) begin
            pulse_ack(); model_ack();
            check_model($sformatf("r%0d_ack", i));
         end
         t0 = tick_total; f0 = fe_total; p0 = pe_total;
         send_frame(d, st, pf, mode == 2, 1'b0);
         model_frame(d, st && !pf, mode == 2);
         check_model($sformatf("r%0d", i));
         check($sformatf("r%0d_fe", i),    32'(fe_total - f0),   32'(!st));
         check($sformatf("r%0d_ticks", i), 32'(tick_total - t0), 32'(NBITS));
         check($sformatf("r%0d_pe", i),    32'(pe_total - p0),   32'(pf));
         idle(2);
      end

      // Reset in the middle of data bit 3.
`ifdef UART_RX_PARITY_EN
      rbits = {1'b1, ^8'h5A, 8'h5A, 1'b0};
`else
      rbits = {1'b1, 8'h5A, 1'b0};
`endif
      for (int c = 0; c <= 4 * CPB + 1; c++) begin
         rx_data = rbits[c / CPB];
         @(posedge clk_25mhz);
         #1;
      end
      #5;
      reset = 1'b1;
      #1;
      check("mid_rst_data",  32'(data_out),    32'h0);
      check("mid_rst_valid", 32'(data_valid),  32'h0);
      check("mid_rst_fe",    32'(frame_error), 32'h0);
      check("mid_rst_ovr",   32'(overrun),     32'h0);
      check("mid_rst_tick",  32'(sample_tick), 32'h0);
      check("mid_rst_busy",  32'(busy),        32'h0);
      rx_data = 1'b1;
      repeat (2) @(posedge clk_25mhz);
      #1;
      reset   = 1'b0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      f0 = fe_total; b0 = busy_total;
      idle(6);
      check("post_rst_busy", 32'(busy_total - b0), 32'h0);
      check_model("post_rst");
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
      model_frame(8'h5A, 1'b1, 1'b0);
      check_model("5a");
      check("5a_fe", 32'(fe_total - f0), 32'h0);
      idle(2);

`ifdef UART_RX_PARITY_EN
      pulse_ack(); model_ack();
      p0 = pe_total;
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      model_frame(8'h5A, 1'b0, 1'b0);
      check("5a_pe", 32'(pe_total - p0), 32'h1);
      check_model("5a_par");
      idle(2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 217, meaning clk_25mhz cycles per bit (25 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL provide port clk_25mhz, input, 1 bit: the single system clock; all state SHALL be clocked by it, with no derived clocks.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port rx_data, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL provide port rd_ack, input, 1 bit: consumer acknowledge of the held data word.
REQ-007 SHALL provide port data_out, output, DATA_BITS bits: last received word, LSB received first.
REQ-008 SHALL provide port data_valid, output, 1 bit: high while data_out holds an unacknowledged word.
REQ-009 SHALL provide port frame_error, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL provide port overrun, output, 1 bit: sticky flag, set when a word is lost.
REQ-011 SHALL provide port sample_tick, output, 1 bit: one-cycle pulse at every mid-bit sample point.
REQ-012 SHALL provide port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 rx_data SHALL pass through a 2-flop synchronizer; rxs denotes the synchronizer output; falling-edge detection SHALL use rxs and one further delayed copy.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-015 A single bit counter SHALL be used, width clog2(CLKS_PER_BIT).
REQ-016 IDLE SHALL go to START on a detected rxs falling edge, loading the counter with CLKS_PER_BIT/2-1 (integer division).
REQ-017 START at counter 0 SHALL pulse sample_tick; if rxs=0 it SHALL go to DATA, otherwise it SHALL return to IDLE (false start, no flags).
REQ-018 In DATA, PARITY and STOP, each counter expiry SHALL occur CLKS_PER_BIT cycles after the previous sample, pulse sample_tick, and sample rxs.
REQ-019 DATA SHALL shift each sampled bit into the MSB of a DATA_BITS shift register, shifting right, and SHALL leave after DATA_BITS samples.
REQ-020 A STOP sample of 1 SHALL, on the same edge, load data_out from the shift register, set data_valid, and return to IDLE.
REQ-021 A STOP sample of 0 SHALL pulse frame_error for one cycle, leave data_out and data_valid unchanged, and return to IDLE.
REQ-022 A low line held after a framing error SHALL NOT retrigger reception until rxs returns high and falls again.
REQ-023 rd_ack while data_valid=1 SHALL clear data_valid and overrun on the next edge.
REQ-024 rd_ack while data_valid=0 SHALL be ignored.
REQ-025 A good frame completing while data_valid=1 SHALL overwrite data_out, keep data_valid=1, and set overrun.
REQ-026 A good frame completing on the same edge as rd_ack SHALL load the new word, keep data_valid=1, and clear overrun (ack consumes the old word).
REQ-027 Latency SHALL be: data_valid visible 1 cycle after the STOP-sample edge, i.e. about 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the rx_data falling edge.

Reset
REQ-028 reset high SHALL asynchronously force: FSM to IDLE; counter, shift register and data_out to 0; data_valid, frame_error, overrun, sample_tick and busy to 0; synchronizer and edge flops to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no partial word and no flags; after release, reception SHALL restart only on a fresh falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined SHALL insert state PARITY after DATA, which samples one even-parity bit.
REQ-031 With UART_RX_PARITY_EN, the block SHALL add output parity_error (1 bit, one-cycle pulse, reset 0), asserted at the STOP sample of a frame whose data bits plus parity bit have odd weight.
REQ-032 With UART_RX_PARITY_EN, a parity-error frame SHALL NOT update data_out or data_valid.
REQ-033 Without UART_RX_PARITY_EN, there SHALL be no PARITY state and no parity_error port, and the frame SHALL be start, DATA_BITS data bits, stop.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-034 Frame 0xA5 with good stop -> data_out=0xA5, data_valid=1, 9 sample_tick pulses after the start sample, frame_error=0.
REQ-035 Then rd_ack for 1 cycle -> data_valid=0 next cycle, data_out holds 0xA5.
REQ-036 Frame 0x3C with stop=0 -> frame_error pulses once, data_valid stays 0; line held low 40 cycles -> busy stays 0.
REQ-037 rx_data low for 1 cycle only -> START entered, then IDLE at the midpoint, no flags, data_valid=0.
REQ-038 Frames 0x11 then 0x22 with no ack -> data_out=0x22, data_valid=1, overrun=1; rd_ack -> both clear.
REQ-039 Reset pulsed during data bit 3 of a frame -> all outputs 0 immediately; next frame 0x5A received correctly; with UART_RX_PARITY_EN, 0x5A with parity bit 1 -> parity_error pulse, data_valid=0.
